// File: rtl/pixel_pkg.sv
// Shared definitions for the RGB test-pattern source: pattern codes,
// FSM states and the fixed colour tables.
package pixel_pkg;

    localparam logic [1:0] PAT_BARS  = 2'd0;
    localparam logic [1:0] PAT_GRAD  = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_PRIM  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PIX,
        ST_GAP,
        ST_DONE
    } state_t;

    // White, yellow, cyan, green, magenta, red, blue, black as {r,g,b}.
    localparam logic [23:0] BAR_RGB [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    function automatic logic [23:0] prim_rgb(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFF0000;
            3'd1:    c = 24'h00FF00;
            3'd2:    c = 24'h0000FF;
            3'd3:    c = 24'hFFFFFF;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rgb_pattern_gen.sv
// Combinational pattern lookup: selects the RGB value for one pixel from
// the pattern code and the per-pixel indices maintained by the source.
module rgb_pattern_gen
    import pixel_pkg::*;
(
    input  logic [1:0] pattern,
    input  logic [2:0] bar,
    input  logic [2:0] prim,
    input  logic [7:0] x,
    input  logic       y_b3,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b
);

    logic [23:0] rgb;

    always_comb begin
        rgb = '0;
        case (pattern)
            PAT_BARS:  rgb = BAR_RGB[bar];
            PAT_GRAD:  rgb = {3{x}};
            PAT_CHECK: rgb = (x[3] ^ y_b3) ? '1 : '0;
            default:   rgb = prim_rgb(prim);
        endcase
    end

    assign {r, g, b} = rgb;

endmodule

// File: rtl/rgb_pixel_source.sv
// Raster test-pattern transmitter with a programmable idle gap after every
// pixel, plus sof/eol/coordinate side-band for downstream consumers.
module rgb_pixel_source
    import pixel_pkg::*;
#(
    parameter int unsigned X_W   = 10,
    parameter int unsigned Y_W   = 10,
    parameter int unsigned MAX_W = 640,
    parameter int unsigned MAX_H = 480
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [X_W-1:0] width,
    input  logic [Y_W-1:0] height,
    input  logic [1:0]     pattern,
    input  logic [3:0]     gap,
    output logic           busy,
    output logic           done,
    output logic           data_valid,
    output logic [7:0]     r,
    output logic [7:0]     g,
    output logic [7:0]     b,
    output logic           sof,
    output logic           eol,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y
);

    localparam logic [X_W-1:0] MAX_W_V = X_W'(MAX_W);
    localparam logic [Y_W-1:0] MAX_H_V = Y_W'(MAX_H);

    state_t         state;
    logic [X_W-1:0] w_r;
    logic [Y_W-1:0] h_r;
    logic [1:0]     pat_r;
    logic [3:0]     gap_r;
    logic [3:0]     gap_cnt;
    logic           last_r;

    // Position/index state of the next pixel to be emitted.
    logic [X_W-1:0] nx;
    logic [Y_W-1:0] ny;
    logic [2:0]     nbar;
    logic [X_W-1:0] nbar_cnt;
    logic [2:0]     nmod;

    logic [X_W-1:0] w_clamp;
    logic [Y_W-1:0] h_clamp;
    logic           zero_frame;
    logic           first;

    logic [X_W-1:0] cur_w;
    logic [Y_W-1:0] cur_h;
    logic [1:0]     cur_pat;
    logic [X_W-1:0] cur_x;
    logic [Y_W-1:0] cur_y;
    logic [2:0]     cur_bar;
    logic [X_W-1:0] cur_cnt;
    logic [2:0]     cur_mod;

    logic [X_W-1:0] bar_w;
    logic           last_col;
    logic           last_pix;
    logic [X_W-1:0] adv_x;
    logic [Y_W-1:0] adv_y;
    logic [2:0]     adv_bar;
    logic [X_W-1:0] adv_cnt;
    logic [2:0]     adv_mod;

    logic           emit;
    logic [7:0]     gen_r;
    logic [7:0]     gen_g;
    logic [7:0]     gen_b;

    assign w_clamp    = (width > MAX_W_V) ? MAX_W_V : width;
    assign h_clamp    = (height > MAX_H_V) ? MAX_H_V : height;
    assign zero_frame = (w_clamp == '0) || (h_clamp == '0);
    assign first      = (state == ST_IDLE);

    // Pixel 0 leaves on the same edge that accepts start, so in IDLE the
    // datapath works from the live inputs and a zeroed position.
    always_comb begin
        cur_w   = first ? w_clamp : w_r;
        cur_h   = first ? h_clamp : h_r;
        cur_pat = first ? pattern : pat_r;
        cur_x   = first ? '0 : nx;
        cur_y   = first ? '0 : ny;
        cur_bar = first ? '0 : nbar;
        cur_cnt = first ? '0 : nbar_cnt;
        cur_mod = first ? '0 : nmod;
    end

    always_comb begin
        bar_w = cur_w >> 3;
        if (bar_w == '0) begin
            bar_w = X_W'(1);
        end
        last_col = (cur_x == cur_w - X_W'(1));
        last_pix = last_col && (cur_y == cur_h - Y_W'(1));
        adv_mod  = (cur_mod == 3'd4) ? 3'd0 : cur_mod + 3'd1;
        if (last_col) begin
            adv_x   = '0;
            adv_y   = cur_y + Y_W'(1);
            adv_bar = '0;
            adv_cnt = '0;
        end else begin
            adv_x = cur_x + X_W'(1);
            adv_y = cur_y;
            if (cur_cnt + X_W'(1) == bar_w) begin
                adv_bar = (cur_bar == 3'd7) ? 3'd7 : cur_bar + 3'd1;
                adv_cnt = '0;
            end else begin
                adv_bar = cur_bar;
                adv_cnt = cur_cnt + X_W'(1);
            end
        end
    end

    always_comb begin
        emit = 1'b0;
        case (state)
            ST_IDLE: emit = start && !zero_frame;
            ST_PIX:  emit = (gap_r == '0) && !last_r;
            ST_GAP:  emit = (gap_cnt == gap_r) && !last_r;
            default: emit = 1'b0;
        endcase
    end

    rgb_pattern_gen u_gen (
        .pattern (cur_pat),
        .bar     (cur_bar),
        .prim    (cur_mod),
        .x       (cur_x[7:0]),
        .y_b3    (cur_y[3]),
        .r       (gen_r),
        .g       (gen_g),
        .b       (gen_b)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            w_r        <= '0;
            h_r        <= '0;
            pat_r      <= '0;
            gap_r      <= '0;
            gap_cnt    <= '0;
            last_r     <= 1'b0;
            nx         <= '0;
            ny         <= '0;
            nbar       <= '0;
            nbar_cnt   <= '0;
            nmod       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            data_valid <= 1'b0;
            r          <= '0;
            g          <= '0;
            b          <= '0;
            sof        <= 1'b0;
            eol        <= 1'b0;
            x          <= '0;
            y          <= '0;
        end else begin
            data_valid <= 1'b0;
            sof        <= 1'b0;
            eol        <= 1'b0;
            done       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        w_r   <= w_clamp;
                        h_r   <= h_clamp;
                        pat_r <= pattern;
                        gap_r <= gap;
                        if (zero_frame) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_PIX: begin
                    if (gap_r != '0) begin
                        state   <= ST_GAP;
                        gap_cnt <= 4'd1;
                    end else if (last_r) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt != gap_r) begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end else if (last_r) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    // A zero-size frame arrives here with busy still low and
                    // spends one extra cycle so its done pulse lands at E0+1.
                    if (busy) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        busy <= 1'b1;
                        done <= 1'b1;
                    end
                end
            endcase
            if (emit) begin
                state      <= ST_PIX;
                busy       <= 1'b1;
                data_valid <= 1'b1;
                r          <= gen_r;
                g          <= gen_g;
                b          <= gen_b;
                x          <= cur_x;
                y          <= cur_y;
                sof        <= first;
                eol        <= last_col;
                last_r     <= last_pix;
                nx         <= adv_x;
                ny         <= adv_y;
                nbar       <= adv_bar;
                nbar_cnt   <= adv_cnt;
                nmod       <= adv_mod;
            end
        end
    end

endmodule

// File: tb/tb_rgb_pixel_source.sv
// Self-checking bench for rgb_pixel_source: a frame-level reference model
// predicts every output cycle by cycle from the frame parameters.
module tb_rgb_pixel_source;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [9:0] width = '0;
    logic [9:0] height = '0;
    logic [1:0] pattern = '0;
    logic [3:0] gap = '0;
    logic       busy, done, data_valid, sof, eol;
    logic [7:0] r, g, b;
    logic [9:0] x, y;

    int total = 0;
    int bad = 0;

    rgb_pixel_source #(.X_W(10), .Y_W(10), .MAX_W(640), .MAX_H(480)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .width      (width),
        .height     (height),
        .pattern    (pattern),
        .gap        (gap),
        .busy       (busy),
        .done       (done),
        .data_valid (data_valid),
        .r          (r),
        .g          (g),
        .b          (b),
        .sof        (sof),
        .eol        (eol),
        .x          (x),
        .y          (y)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] model_rgb(input int pat, input int px, input int py,
                                              input int k, input int w);
        logic [23:0] bars [8];
        logic [23:0] prim [5];
        int bw, idx, gv;
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        prim = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF, 24'h000000};
        case (pat)
            0: begin
                bw = w / 8;
                if (bw < 1) bw = 1;
                idx = px / bw;
                if (idx > 7) idx = 7;
                return bars[idx];
            end
            1: begin
                gv = px % 256;
                return {gv[7:0], gv[7:0], gv[7:0]};
            end
            2: return ((((px / 8) % 2) ^ ((py / 8) % 2)) != 0) ? 24'hFFFFFF : 24'h000000;
            default: return prim[k % 5];
        endcase
    endfunction

    // Starts a frame and checks every cycle through the idle cycle after done.
    // pulse_at re-asserts start mid-frame; abort_at applies reset at that cycle.
    task automatic run_frame(input string name, input int w, input int h, input int pat,
                             input int gp, input bit hold, input int pulse_at,
                             input int abort_at);
        int ew, eh, n, per, dl, k, ex, ey;
        bit zero, exp_v, exp_busy;
        logic [23:0] exp_rgb;
        width   = 10'(w);
        height  = 10'(h);
        pattern = 2'(pat);
        gap     = 4'(gp);
        start   = 1'b1;
        ew   = (w > 640) ? 640 : w;
        eh   = (h > 480) ? 480 : h;
        n    = ew * eh;
        per  = gp + 1;
        zero = (n == 0);
        dl   = zero ? 1 : n * per;
        for (int c = 0; c <= dl + 1; c++) begin
            @(posedge clk);
            #1;
            exp_v    = !zero && (c < dl) && (c % per == 0);
            exp_busy = zero ? (c == 1) : (c <= dl);
            k  = c / per;
            ex = (ew == 0) ? 0 : k % ew;
            ey = (ew == 0) ? 0 : k / ew;
            total++;
            if (data_valid !== exp_v) begin
                bad++;
                $display("FAIL %s valid c=%0d got=%b want=%b", name, c, data_valid, exp_v);
            end
            total++;
            if (done !== (c == dl)) begin
                bad++;
                $display("FAIL %s done c=%0d got=%b want=%b", name, c, done, (c == dl));
            end
            total++;
            if (busy !== exp_busy) begin
                bad++;
                $display("FAIL %s busy c=%0d got=%b want=%b", name, c, busy, exp_busy);
            end
            if (exp_v) begin
                exp_rgb = model_rgb(pat, ex, ey, k, ew);
                total++;
                if ({r, g, b} !== exp_rgb) begin
                    bad++;
                    $display("FAIL %s rgb (%0d,%0d) got=%06h want=%06h", name, ex, ey, {r, g, b}, exp_rgb);
                end
                total++;
                if (x !== 10'(ex) || y !== 10'(ey)) begin
                    bad++;
                    $display("FAIL %s xy k=%0d got=(%0d,%0d) want=(%0d,%0d)", name, k, x, y, ex, ey);
                end
                total++;
                if (sof !== (k == 0) || eol !== (ex == ew - 1)) begin
                    bad++;
                    $display("FAIL %s sof/eol (%0d,%0d) got=%b%b want=%b%b", name, ex, ey,
                             sof, eol, (k == 0), (ex == ew - 1));
                end
            end else begin
                total++;
                if (sof !== 1'b0 || eol !== 1'b0) begin
                    bad++;
                    $display("FAIL %s idle sof/eol c=%0d got=%b%b want=00", name, c, sof, eol);
                end
            end
            if (c == abort_at) begin
                start = 1'b0;
                rst_n = 1'b0;
                @(posedge clk);
                #1;
                total++;
                if ({busy, done, data_valid, r, g, b, sof, eol, x, y} !== '0) begin
                    bad++;
                    $display("FAIL %s abort outputs got=%b/%b/%b rgb=%06h xy=(%0d,%0d) want all 0",
                             name, busy, done, data_valid, {r, g, b}, x, y);
                end
                rst_n = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    @(posedge clk);
                    #1;
                    total++;
                    if (done !== 1'b0 || busy !== 1'b0 || data_valid !== 1'b0) begin
                        bad++;
                        $display("FAIL %s post-abort c=%0d got done=%b busy=%b dv=%b want 000",
                                 name, i, done, busy, data_valid);
                    end
                end
                return;
            end
            // Scramble unlatched inputs so any use of live values shows up.
            start   = hold ? 1'b1 : (c == pulse_at);
            width   = 10'($urandom_range(0, 1023));
            height  = 10'($urandom_range(0, 1023));
            pattern = 2'($urandom_range(0, 3));
            gap     = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        width = 10'd8;
        height = 10'd2;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++;
            if ({busy, done, data_valid, r, g, b, sof, eol, x, y} !== '0) begin
                bad++;
                $display("FAIL reset outputs cyc=%0d got=%b/%b/%b rgb=%06h want all 0",
                         i, busy, done, data_valid, {r, g, b});
            end
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || data_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset idle got busy=%b dv=%b want 00", busy, data_valid);
        end
    endtask

    task automatic test_primary();
        run_frame("prim", 5, 1, 3, 4, 1'b0, -1, -1);
    endtask

    task automatic test_bars();
        run_frame("bars", 16, 2, 0, 0, 1'b0, -1, -1);
        run_frame("bars_sat", 20, 1, 0, 1, 1'b0, -1, -1);
        run_frame("bars_narrow", 5, 2, 0, 0, 1'b0, -1, -1);
    endtask

    task automatic test_zero_size();
        run_frame("zero_w", 0, 4, 1, 2, 1'b0, -1, -1);
        run_frame("zero_h", 7, 0, 0, 0, 1'b0, -1, -1);
    endtask

    task automatic test_clamp_busy();
        run_frame("clamp", 1000, 1, 1, 0, 1'b0, 300, -1);
        run_frame("w1", 1, 3, 2, 1, 1'b0, 1, -1);
    endtask

    task automatic test_reset_mid();
        run_frame("abort", 32, 32, 2, 0, 1'b0, -1, 100);
        run_frame("after_abort", 16, 1, 2, 0, 1'b0, -1, -1);
    endtask

    task automatic test_back_to_back();
        run_frame("b2b_a", 6, 2, 3, 0, 1'b1, -1, -1);
        run_frame("b2b_b", 9, 2, 1, 2, 1'b0, -1, -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            run_frame("rand", int'($urandom_range(0, 20)), int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, -1, -1);
        end
        run_frame("rand_wide", int'($urandom_range(30, 90)), 2, 0, 0, 1'b0, -1, -1);
        run_frame("rand_check", 24, 20, 2, 0, 1'b0, -1, -1);
    endtask

    initial begin
        test_reset();
        test_primary();
        test_bars();
        test_zero_size();
        test_clamp_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
